// File: rtl/mult_seq_controller.sv
// rtl/mult_seq_controller.sv - Moore FSM sequencing the shift-add multiplier datapath
// Optional early termination when remaining multiplier bits are zero: EARLY_EXIT_EN
module mult_seq_controller #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             b_lsb,
    input  logic             b_zero,
    output logic             ld_ops,
    output logic             clr_prod,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] iter_inc;
    logic             exit_now;

    assign iter_inc = iter + 1'b1;

`ifdef EARLY_EXIT_EN
    // Once the unconsumed multiplier bits are all zero no further add can change P.
    assign exit_now = (iter_inc == ITER_LAST) || b_zero;
`else
    logic unused_b_zero;
    assign unused_b_zero = b_zero;
    assign exit_now      = (iter_inc == ITER_LAST);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ADD;
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = exit_now ? S_DONE : S_ADD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= S_IDLE;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_LOAD) begin
                iter <= '0;
            end else if (state == S_SHIFT && iter != ITER_LAST) begin
                iter <= iter_inc;
            end
        end
    end

    assign ld_ops   = (state == S_LOAD);
    assign clr_prod = (state == S_LOAD);
    assign add_en   = (state == S_ADD) && b_lsb;
    assign shift_en = (state == S_SHIFT);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_mult_seq_controller.sv
// tb/tb_mult_seq_controller.sv - directed self-checking bench for mult_seq_controller
module tb_mult_seq_controller;

    logic       clk;
    logic       clr;
    logic       start;
    logic       b_lsb;
    logic       b_zero;
    logic       ld_ops;
    logic       clr_prod;
    logic       add_en;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [2:0] iter;

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus masks (bit c applies to cycle c) and observations
    logic [63:0] pulse_mask;
    logic [63:0] lsb_mask;
    logic [63:0] bz_mask;
    logic        start_hold;
    int          clr_cycle;
    logic [5:0]  obs [0:63];
    logic [2:0]  obs_iter [0:63];

    // {busy, done, ld_ops, clr_prod, add_en, shift_en} for B=4'b1101
    logic [5:0]  exp2 [1:12];

    mult_seq_controller #(.WIDTH(4), .CNT_W(3)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .b_lsb    (b_lsb),
        .b_zero   (b_zero),
        .ld_ops   (ld_ops),
        .clr_prod (clr_prod),
        .add_en   (add_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .iter     (iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulse start at edge 0 then run n cycles, sampling just after inputs settle mid-cycle.
    task automatic run(input int n);
        @(negedge clk);
        clr    = 1'b1;
        start  = 1'b1;
        b_lsb  = 1'b0;
        b_zero = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start  = start_hold | pulse_mask[c];
            b_lsb  = lsb_mask[c];
            b_zero = bz_mask[c];
            clr    = (c == clr_cycle) ? 1'b0 : 1'b1;
            #1;
            obs[c]      = {busy, done, ld_ops, clr_prod, add_en, shift_en};
            obs_iter[c] = iter;
        end
        @(negedge clk);
        start = 1'b0;
        clr   = 1'b1;
    endtask

    task automatic set_stim(input logic hold, input logic [63:0] pm, input logic [63:0] lm,
                            input logic [63:0] bm, input int cc);
        start_hold = hold;
        pulse_mask = pm;
        lsb_mask   = lm;
        bz_mask    = bm;
        clr_cycle  = cc;
    endtask

    initial begin
        int dcount;
        int dcycle;
        exp2[1]  = 6'b101100;
        exp2[2]  = 6'b100010;
        exp2[3]  = 6'b100001;
        exp2[4]  = 6'b100000;
        exp2[5]  = 6'b100001;
        exp2[6]  = 6'b100010;
        exp2[7]  = 6'b100001;
        exp2[8]  = 6'b100010;
        exp2[9]  = 6'b100001;
        exp2[10] = 6'b110000;
        exp2[11] = 6'b000000;
        exp2[12] = 6'b000000;

        // Reset with start asserted
        clr = 1'b0; start = 1'b1; b_lsb = 1'b1; b_zero = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", 32'({busy, done, ld_ops, clr_prod, add_en, shift_en}), 32'd0);
        check("reset_iter", 32'(iter), 32'd0);
        start = 1'b0;
        clr   = 1'b1;
        @(negedge clk);
        check("idle_flags", 32'({busy, done, ld_ops, clr_prod, add_en, shift_en}), 32'd0);

        // Basic run, B=4'b1101
        set_stim(1'b0, 64'h0, 64'h144, 64'h0, -1);
        run(12);
        for (int c = 1; c <= 12; c++) check($sformatf("basic_c%0d", c), 32'(obs[c]), 32'(exp2[c]));
        check("basic_iter_c3", 32'(obs_iter[3]), 32'd0);
        check("basic_iter_c4", 32'(obs_iter[4]), 32'd1);
        check("basic_iter_c8", 32'(obs_iter[8]), 32'd3);
        check("basic_iter_c10", 32'(obs_iter[10]), 32'd4);
        check("basic_iter_c12", 32'(obs_iter[12]), 32'd4);

        // start re-pulsed while busy
        set_stim(1'b0, 64'h410, 64'h144, 64'h0, -1);
        run(14);
        dcount = 0;
        for (int c = 1; c <= 14; c++) dcount += int'(obs[c][4]);
        check("repulse_done_count", 32'(dcount), 32'd1);
        check("repulse_done_c10", 32'(obs[10][4]), 32'd1);
        check("repulse_busy_c11", 32'(obs[11][5]), 32'd0);
        check("repulse_busy_c13", 32'(obs[13][5]), 32'd0);

        // Reset during SHIFT of iteration 2
        set_stim(1'b0, 64'h0, 64'h144, 64'h0, 5);
        run(26);
        check("abort_c5_shift", 32'(obs[5]), 32'(6'b100001));
        check("abort_c6_flags", 32'(obs[6]), 32'd0);
        check("abort_c6_iter", 32'(obs_iter[6]), 32'd0);
        dcount = 0;
        for (int c = 6; c <= 26; c++) dcount += int'(obs[c][4]) + int'(obs[c][5]);
        check("abort_no_activity", 32'(dcount), 32'd0);

        // B=4'b0001: remaining bits zero from the first SHIFT on
        set_stim(1'b0, 64'h0, 64'h4, 64'hFFFF_FFFF_FFFF_FFFF, -1);
        run(12);
        dcount = 0;
        dcycle = 0;
        for (int c = 1; c <= 12; c++) begin
            dcount += int'(obs[c][4]);
            if (obs[c][4]) dcycle = c;
        end
        check("early_done_count", 32'(dcount), 32'd1);
`ifdef EARLY_EXIT_EN
        check("early_done_cycle", 32'(dcycle), 32'd4);
        check("early_iter", 32'(obs_iter[4]), 32'd1);
        check("early_busy_c5", 32'(obs[5][5]), 32'd0);
`else
        check("early_done_cycle", 32'(dcycle), 32'd10);
        check("early_iter", 32'(obs_iter[10]), 32'd4);
        check("early_busy_c5", 32'(obs[5][5]), 32'd1);
`endif
        check("early_add_c2", 32'(obs[2][1]), 32'd1);

        // start held high: back-to-back runs every 11 cycles
        set_stim(1'b1, 64'h0, 64'h0, 64'h0, -1);
        run(40);
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("hold_done_c%0d", c), 32'(obs[c][4]),
                  32'((c == 10) || (c == 21) || (c == 32)));
            check($sformatf("hold_busy_c%0d", c), 32'(obs[c][5]),
                  32'(!((c == 11) || (c == 22) || (c == 33))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
